// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_tx
// Purpose  : Serial pattern transmitter. Shifts a captured PAT_W-bit pattern
//            out MSB-first, repeated repeat_cnt times, honouring stall/abort.
//            Define SEQ_PATTERN_TX_GAP_EN for a one-cycle gap between copies.
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_tx #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             stall,
    input  logic             abort,
    output logic             valid,
    output logic             d_out,
    output logic             busy,
    output logic             pat_sent,
    output logic             done
);

    localparam int                 c_idx_w    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(PAT_W - 1);
    localparam logic [CNT_W-1:0]   c_one      = CNT_W'(1);

    generate
        if (PAT_W < 2) begin : g_bad_pat_w
            $error("seq_pattern_tx: PAT_W must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
`ifdef SEQ_PATTERN_TX_GAP_EN
        ,
        ST_GAP  = 2'd3
`endif
    } state_t;

    state_t             r_state;
    logic [PAT_W-1:0]   pat_q;
    logic [CNT_W-1:0]   rep_q;
    logic [c_idx_w-1:0] bit_idx;

    logic w_emit;

    // A bit goes out only in an unstalled, unaborted SEND cycle.
    assign w_emit = (r_state == ST_SEND) && !stall && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            pat_q   <= '0;
            rep_q   <= '0;
            bit_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        pat_q   <= pattern;
                        rep_q   <= repeat_cnt;
                        bit_idx <= c_last_idx;
                        r_state <= (repeat_cnt != '0) ? ST_SEND : ST_DONE;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (!stall) begin
                        if (bit_idx != '0) begin
                            bit_idx <= bit_idx - c_idx_w'(1);
                        end else begin
                            bit_idx <= c_last_idx;
                            rep_q   <= rep_q - c_one;
                            if (rep_q == c_one) begin
                                r_state <= ST_DONE;
                            end else begin
`ifdef SEQ_PATTERN_TX_GAP_EN
                                r_state <= ST_GAP;
`else
                                r_state <= ST_SEND;
`endif
                            end
                        end
                    end
                end
`ifdef SEQ_PATTERN_TX_GAP_EN
                ST_GAP: begin
                    r_state <= abort ? ST_IDLE : ST_SEND;
                end
`endif
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        valid    = w_emit;
        d_out    = w_emit ? pat_q[bit_idx] : 1'b0;
        busy     = (r_state != ST_IDLE);
        pat_sent = w_emit && (bit_idx == '0);
        done     = (r_state == ST_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_pattern_tx
// Purpose  : Self-checking bench for seq_pattern_tx (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] pattern;
    logic [7:0] repeat_cnt;
    logic       stall;
    logic       abort;
    logic       valid, d_out, busy, pat_sent, done;

    seq_pattern_tx #(.PAT_W(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .stall      (stall),
        .abort      (abort),
        .valid      (valid),
        .d_out      (d_out),
        .busy       (busy),
        .pat_sent   (pat_sent),
        .done       (done)
    );

    always #5 clk = ~clk;

    // exp = {valid, d_out, busy, pat_sent, done}
    typedef struct {
        bit         st;
        logic [3:0] pat;
        logic [7:0] rep;
        bit         sl;
        bit         ab;
        logic [4:0] exp;
        int         tag;
    } vec_t;

    vec_t       vecs[$];
    logic [4:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] det_sh = 4'b0;
    int         det_cnt = 0;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void add(input bit st, input logic [3:0] p, input logic [7:0] r,
                                input bit sl, input bit ab, input logic [4:0] e, input int tag);
        vec_t v;
        v.st = st; v.pat = p; v.rep = r; v.sl = sl; v.ab = ab; v.exp = e; v.tag = tag;
        vecs.push_back(v);
    endfunction

    function automatic void add_idle(input int tag);
        add(1'b0, 4'hF, 8'd3, 1'b1, 1'b1, 5'b00000, tag);
    endfunction

    // Expected cycle stream of one transfer: start row, bits, stalls, gaps, done.
    // Non-start rows carry junk start/pattern/count that must be ignored.
    function automatic void gen_xfer(input logic [3:0] p, input int r, input logic [63:0] smask,
                                     input int abort_at, input int tag);
        int cyc    = 1;
        int bitn   = 3;
        int copies = 0;
        bit sl;
        add(1'b1, p, 8'(r), 1'b0, 1'b1, 5'b00000, tag);
        for (int guard = 0; guard < 5000; guard++) begin
            sl = (cyc < 64) ? smask[cyc] : 1'b0;
            if (cyc == abort_at) begin
                add(1'b0, ~p, 8'd7, sl, 1'b1, 5'b00100, tag);
                return;
            end
            if (sl) begin
                add(cyc[0], ~p, 8'd5, 1'b1, 1'b0, 5'b00100, tag);
            end else begin
                add(cyc[0], ~p, 8'd5, 1'b0, 1'b0, {1'b1, p[bitn], 1'b1, (bitn == 0), 1'b0}, tag);
                if (bitn > 0) begin
                    bitn--;
                end else begin
                    bitn = 3;
                    copies++;
                    if (copies == r) begin
                        add(1'b1, ~p, 8'd5, 1'b1, 1'b1, 5'b00101, tag);
                        return;
                    end
`ifdef SEQ_PATTERN_TX_GAP_EN
                    cyc++;
                    add(cyc[0], ~p, 8'd5, 1'b1, 1'b0, 5'b00100, tag);
`endif
                end
            end
            cyc++;
        end
    endfunction

    task automatic check_row(input int idx, input int tag);
        logic [4:0] e;
        if (exp_q.size() == 0) begin
            cmp($sformatf("scoreboard_empty_row%0d", idx), 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        cmp($sformatf("case%0d_row%0d {valid,d_out,busy,pat_sent,done}", tag, idx),
            {27'd0, valid, d_out, busy, pat_sent, done}, {27'd0, e});
        if (valid) begin
            det_sh = {det_sh[2:0], d_out};
            if (det_sh == 4'b1110) det_cnt++;
        end
    endtask

    // Entered and left at posedge+1.
    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) begin
            start      = vecs[i].st;
            pattern    = vecs[i].pat;
            repeat_cnt = vecs[i].rep;
            stall      = vecs[i].sl;
            abort      = vecs[i].ab;
            exp_q.push_back(vecs[i].exp);
            @(negedge clk);
            check_row(i, vecs[i].tag);
            @(posedge clk);
            #1;
        end
        vecs.delete();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; pattern = 4'h0; repeat_cnt = 8'd0;
        stall = 1'b0; abort = 1'b0;
        #12;
        cmp("reset_outputs", {27'd0, valid, d_out, busy, pat_sent, done}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1110 x2 back-to-back; detector should see two occurrences
        gen_xfer(4'b1110, 2, 64'd0, 0, 1);
        add_idle(1);
        det_sh = 4'b0; det_cnt = 0;
        run_vecs();
        cmp("detector_1110_count", det_cnt, 2);

        // stalls on cycles 2-3
        gen_xfer(4'b1110, 2, 64'b1100, 0, 2);
        add_idle(2);

        // zero-length transfer; start held through DONE is taken only in IDLE
        add(1'b1, 4'b1010, 8'd0, 1'b0, 1'b0, 5'b00000, 3);
        add(1'b1, 4'b1010, 8'd0, 1'b0, 1'b0, 5'b00101, 3);
        add(1'b1, 4'b1010, 8'd0, 1'b0, 1'b0, 5'b00000, 3);
        add(1'b0, 4'b1010, 8'd0, 1'b0, 1'b0, 5'b00101, 3);
        add_idle(3);

        // abort (with stall) at the third bit of copy 2, then an immediate restart
        gen_xfer(4'b1011, 3, 64'd1 << 7, 7, 4);
        gen_xfer(4'b0110, 1, 64'd0, 0, 4);
        add_idle(4);

        // maximum repeat count
        gen_xfer(4'b1001, 255, 64'd0, 0, 6);
        add_idle(6);
        run_vecs();

        // asynchronous reset mid-copy
        add(1'b1, 4'b1110, 8'd2, 1'b0, 1'b0, 5'b00000, 5);
        add(1'b0, 4'b0000, 8'd0, 1'b0, 1'b0, 5'b11100, 5);
        add(1'b0, 4'b0000, 8'd0, 1'b0, 1'b0, 5'b11100, 5);
        run_vecs();
        start = 1'b0; stall = 1'b0; abort = 1'b0;
        #2;
        cmp("pre_reset_bit", {27'd0, valid, d_out, busy, pat_sent, done}, 32'b11100);
        rst_n = 1'b0;
        #1;
        cmp("async_reset_outputs", {27'd0, valid, d_out, busy, pat_sent, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) add(1'b0, 4'b1111, 8'd9, 1'b0, 1'b0, 5'b00000, 5);

        // three copies (gaps appear when the gap build is selected)
        gen_xfer(4'b1110, 3, 64'd0, 0, 7);
        add_idle(7);
        run_vecs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
